// File: rtl/limd_pkg.sv
// limd_pkg -- shared definitions for the LIMD channel scheduler.
//   state_t : scheduler FSM states
//   DW_DEF  : default operand/result width
//   A1_LIM  : magnitude bound applied to A1 when a result has to be synthesised
package limd_pkg;

    localparam int DW_DEF = 16;
    localparam int A1_LIM = 15360;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter -- combinational round-robin find-first.
// Searches req starting at last+1 and wrapping modulo NCH, so the channel
// served most recently has the lowest priority.
// Ports:
//   req    in  NCH  request levels
//   last   in  CHW  most recently granted channel
//   enable in  1    arbitration allowed this cycle
//   grant  out NCH  one-hot winner (all zero if none or disabled)
//   index  out CHW  winner index
//   valid  out 1    a winner exists
module rr_arbiter
    import limd_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CHW = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [CHW-1:0] last,
    input  logic           enable,
    output logic [NCH-1:0] grant,
    output logic [CHW-1:0] index,
    output logic           valid
);

    logic [CHW-1:0] cand;

    always_comb begin
        grant = '0;
        index = '0;
        valid = 1'b0;
        cand  = '0;
        for (int i = 1; i <= NCH; i++) begin
            cand = CHW'((int'(last) + i) % NCH);
            if (enable && !valid && req[cand]) begin
                valid       = 1'b1;
                grant[cand] = 1'b1;
                index       = cand;
            end
        end
    end

endmodule

// File: rtl/limd_chan_sched.sv
// limd_chan_sched -- round-robin scheduler sharing one LIMD coefficient
// limiter among NCH ADPCM channel engines.
// Optional build macro: LIMD_SCHED_TIMEOUT_EN bounds the WAIT state to TMO
// cycles and substitutes a clamped A1 (err=1) when the limiter never answers.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   req, a1t, a2p         per-channel request level and packed operands
//   ack, a1p, err         one-hot completion pulse, result, timeout flag
//   busy, grant_id        not-idle indication, current/last granted channel
//   lim_start, lim_a1t,
//   lim_a2p               start pulse and latched operands to the LIMD unit
//   lim_done, lim_a1p     LIMD result-valid pulse and result
//
// state | meaning
// IDLE  | waiting for any req; arbitrates and latches operands on a hit
// ISSUE | lim_start pulse to the LIMD unit
// WAIT  | waiting for lim_done (or timeout when enabled)
// RESP  | ack of the granted channel with a1p for one cycle
module limd_chan_sched
    import limd_pkg::*;
#(
    parameter int NCH = 4,
    parameter int DW  = DW_DEF,
    parameter int CHW = $clog2(NCH),
    parameter int TMO = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH-1:0]    req,
    input  logic [NCH*DW-1:0] a1t,
    input  logic [NCH*DW-1:0] a2p,
    output logic [NCH-1:0]    ack,
    output logic [DW-1:0]     a1p,
    output logic              err,
    output logic              busy,
    output logic [CHW-1:0]    grant_id,
    output logic              lim_start,
    output logic [DW-1:0]     lim_a1t,
    output logic [DW-1:0]     lim_a2p,
    input  logic              lim_done,
    input  logic [DW-1:0]     lim_a1p
);

    if (NCH < 2 || NCH > 32 || TMO < 2) begin : g_bad_param
        $error("limd_chan_sched: NCH must be 2..32 and TMO at least 2");
    end

    state_t         state, state_nxt;
    logic [CHW-1:0] last;
    logic [NCH-1:0] ack_sel;
    logic [DW-1:0]  result;
    logic [NCH-1:0] arb_grant;
    logic [CHW-1:0] arb_index;
    logic           arb_valid;
    logic           tmo_hit;

    rr_arbiter #(.NCH(NCH), .CHW(CHW)) u_arb (
        .req    (req),
        .last   (last),
        .enable (state == IDLE),
        .grant  (arb_grant),
        .index  (arb_index),
        .valid  (arb_valid)
    );

`ifdef LIMD_SCHED_TIMEOUT_EN
    localparam int TMR_W = $clog2(TMO);
    localparam logic signed [DW-1:0] A1_POS = DW'(A1_LIM);
    localparam logic signed [DW-1:0] A1_NEG = -A1_POS;

    logic [TMR_W-1:0]      tmr;
    logic                  err_q;
    logic signed [DW-1:0]  a1t_s;
    logic [DW-1:0]         a1t_clamped;

    assign tmo_hit = (tmr == '0);
    assign a1t_s   = signed'(lim_a1t);

    always_comb begin
        a1t_clamped = lim_a1t;
        if (a1t_s > A1_POS) begin
            a1t_clamped = A1_POS;
        end else if (a1t_s < A1_NEG) begin
            a1t_clamped = A1_NEG;
        end
    end

    // Down-counter loaded during ISSUE so WAIT sees exactly TMO cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmr   <= '0;
            err_q <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                tmr <= TMR_W'(TMO - 1);
            end else if (state == WAIT && !lim_done && !tmo_hit) begin
                tmr <= tmr - 1'b1;
            end
            if (state == WAIT) begin
                if (lim_done) begin
                    err_q <= 1'b0;
                end else if (tmo_hit) begin
                    err_q <= 1'b1;
                end
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ack       = '0;
        a1p       = '0;
        err       = 1'b0;
        busy      = (state != IDLE);
        lim_start = 1'b0;
        case (state)
            IDLE:  if (arb_valid) state_nxt = ISSUE;
            ISSUE: begin
                lim_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT:  if (lim_done || tmo_hit) state_nxt = RESP;
            RESP:  begin
                ack       = ack_sel;
                a1p       = result;
`ifdef LIMD_SCHED_TIMEOUT_EN
                err       = err_q;
`endif
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last     <= CHW'(NCH - 1);
            grant_id <= '0;
            ack_sel  <= '0;
            lim_a1t  <= '0;
            lim_a2p  <= '0;
            result   <= '0;
        end else begin
            if (state == IDLE && arb_valid) begin
                grant_id <= arb_index;
                last     <= arb_index;
                ack_sel  <= arb_grant;
                lim_a1t  <= a1t[arb_index*DW +: DW];
                lim_a2p  <= a2p[arb_index*DW +: DW];
            end
            if (state == WAIT) begin
                if (lim_done) begin
                    result <= lim_a1p;
                end
`ifdef LIMD_SCHED_TIMEOUT_EN
                else if (tmo_hit) begin
                    result <= a1t_clamped;
                end
`endif
            end
        end
    end

endmodule
